scalar_multiply_unit: RTL and testbench

Multiplies every element of a matrix of up to 5×5 elements by a 4-bit unsigned scalar and registers the result. It sits in the Calculation datapath beside the other matrix operation units. It shares their flat 200-bit matrix bus format and the m/n dimension convention. The unit checks the dimensions and flags invalid inputs through `valid`.

---
 rtl/scalar_multiply_unit_pkg.sv | 17 +
 rtl/scalar_mul_elem.sv | 18 +
 rtl/scalar_multiply_unit.sv | 48 ++++
 tb/tb_scalar_multiply_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/scalar_multiply_unit_pkg.sv
// Shared constants for the matrix operation units: a flat row-major bus of
// up to 5x5 unsigned 8-bit elements, plus the element-offset helper.
package scalar_multiply_unit_pkg;

    localparam int MAX_DIM  = 5;
    localparam int ELEM_W   = 8;
    localparam int SCALAR_W = 4;
    localparam int MAT_W    = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int DIM_W    = 3;
    localparam int PROD_W   = ELEM_W + SCALAR_W;

    // Bit offset of element (r,c) within the flat matrix bus.
    function automatic int idx(input int r, input int c);
        return (r * MAX_DIM + c) * ELEM_W;
    endfunction

endpackage

// File: rtl/scalar_mul_elem.sv
// One element lane: full-width product of element and scalar, truncated to
// the element width and forced to zero when the lane is disabled.
module scalar_mul_elem
    import scalar_multiply_unit_pkg::*;
(
    input  logic [ELEM_W-1:0]   elem,
    input  logic [SCALAR_W-1:0] scalar,
    input  logic                enable,
    output logic [ELEM_W-1:0]   product
);

    logic [PROD_W-1:0] full_product;

    // Operands widen to the 12-bit context, so no high bits are lost before truncation.
    assign full_product = elem * scalar;
    assign product      = enable ? full_product[ELEM_W-1:0] : '0;

endmodule

// File: rtl/scalar_multiply_unit.sv
// Multiplies every in-region element of an m x n matrix by a 4-bit scalar
// (modulo 256) and registers the result with a dimension-legality flag.
module scalar_multiply_unit
    import scalar_multiply_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DIM_W-1:0]    m,
    input  logic [DIM_W-1:0]    n,
    input  logic [SCALAR_W-1:0] scalarValue,
    input  logic [MAT_W-1:0]    matrix_in,
    output logic [MAT_W-1:0]    matrix_out,
    output logic                valid
);

    logic             dims_ok;
    logic [MAT_W-1:0] result;

    assign dims_ok = (m >= DIM_W'(1)) && (m <= DIM_W'(MAX_DIM)) &&
                     (n >= DIM_W'(1)) && (n <= DIM_W'(MAX_DIM));

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            logic enable;

            assign enable = dims_ok && (DIM_W'(r) < m) && (DIM_W'(c) < n);

            scalar_mul_elem u_elem (
                .elem    (matrix_in[idx(r, c) +: ELEM_W]),
                .scalar  (scalarValue),
                .enable  (enable),
                .product (result[idx(r, c) +: ELEM_W])
            );
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix_out <= '0;
            valid      <= 1'b0;
        end else begin
            matrix_out <= result;
            valid      <= dims_ok;
        end
    end

endmodule

// File: tb/tb_scalar_multiply_unit.sv
// Directed and randomized checks of scalar_multiply_unit against an
// arithmetic reference model of the matrix-times-scalar operation.
module tb_scalar_multiply_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   m;
    logic [2:0]   n;
    logic [3:0]   scalar_value;
    logic [199:0] matrix_in;
    logic [199:0] matrix_out;
    logic         valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [199:0] exp_mat;
    logic         exp_valid;
    logic [199:0] held_mat;
    logic         held_valid;
    logic [199:0] mat;

    scalar_multiply_unit dut (
        .clk         (clk),
        .reset       (reset),
        .m           (m),
        .n           (n),
        .scalarValue (scalar_value),
        .matrix_in   (matrix_in),
        .matrix_out  (matrix_out),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [199:0] put(input logic [199:0] mt, input int r, input int c,
                                         input logic [7:0] v);
        logic [199:0] t = mt;
        t[(r * 5 + c) * 8 +: 8] = v;
        return t;
    endfunction

    // Reference: legal dims give (a*s) mod 256 inside the m x n region, zero elsewhere.
    function automatic logic [200:0] model(input int mm, input int nn, input int s,
                                           input logic [199:0] mt);
        logic [199:0] o  = '0;
        bit           ok = (mm >= 1) && (mm <= 5) && (nn >= 1) && (nn <= 5);
        if (ok) begin
            for (int r = 0; r < mm; r++)
                for (int c = 0; c < nn; c++)
                    o[(r * 5 + c) * 8 +: 8] = 8'((int'(mt[(r * 5 + c) * 8 +: 8]) * s) % 256);
        end
        return {ok, o};
    endfunction

    task automatic check_mat(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply(input int mm, input int nn, input int s, input logic [199:0] mt);
        logic [200:0] r;
        m            = 3'(mm);
        n            = 3'(nn);
        scalar_value = 4'(s);
        matrix_in    = mt;
        r            = model(mm, nn, s, mt);
        exp_valid    = r[200];
        exp_mat      = r[199:0];
    endtask

    task automatic step_and_check(input string tag);
        @(posedge clk);
        #1;
        check_mat({tag, "_mat"}, matrix_out, exp_mat);
        check_bit({tag, "_valid"}, valid, exp_valid);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        apply(2, 2, 5, {25{8'd9}});
        #1;
        check_mat("reset_initial_mat", matrix_out, '0);
        check_bit("reset_initial_valid", valid, 1'b0);
        @(posedge clk);
        #1;
        check_mat("reset_held_mat", matrix_out, '0);
        check_bit("reset_held_valid", valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Basic 2x3 with explicit expected values.
        mat = '0;
        mat = put(mat, 0, 0, 8'd1); mat = put(mat, 0, 1, 8'd2); mat = put(mat, 0, 2, 8'd3);
        mat = put(mat, 1, 0, 8'd3); mat = put(mat, 1, 1, 8'd4); mat = put(mat, 1, 2, 8'd5);
        apply(2, 3, 3, mat);
        exp_mat = '0;
        exp_mat = put(exp_mat, 0, 0, 8'd3); exp_mat = put(exp_mat, 0, 1, 8'd6);
        exp_mat = put(exp_mat, 0, 2, 8'd9); exp_mat = put(exp_mat, 1, 0, 8'd9);
        exp_mat = put(exp_mat, 1, 1, 8'd12); exp_mat = put(exp_mat, 1, 2, 8'd15);
        exp_valid = 1'b1;
        step_and_check("basic_2x3");

        // Wrap-around: 255*15 = 3825 -> 241; 200*3 = 600 -> 88.
        apply(5, 5, 15, {25{8'd255}});
        exp_mat = {25{8'd241}};
        step_and_check("wrap_255x15");
        apply(1, 1, 3, {192'd0, 8'd200});
        exp_mat = {192'd0, 8'd88};
        step_and_check("wrap_200x3");

        // Masking outside a 1x1 region.
        apply(1, 1, 2, {25{8'd7}});
        exp_mat = {192'd0, 8'd14};
        step_and_check("mask_1x1");

        // Illegal dimensions and the legal zero-scalar case.
        apply(0, 3, 5, {25{8'h5a}});
        exp_mat = '0; exp_valid = 1'b0;
        step_and_check("illegal_m0");
        apply(6, 2, 5, {25{8'h5a}});
        exp_mat = '0; exp_valid = 1'b0;
        step_and_check("illegal_m6");
        apply(3, 7, 5, {25{8'h5a}});
        exp_mat = '0; exp_valid = 1'b0;
        step_and_check("illegal_n7");
        apply(5, 5, 0, {25{8'h5a}});
        exp_mat = '0; exp_valid = 1'b1;
        step_and_check("scalar_zero");

        // Latency: a mid-cycle input change stays invisible until the next edge.
        apply(4, 3, 6, {25{8'd11}});
        step_and_check("latency_a");
        held_mat   = exp_mat;
        held_valid = exp_valid;
        apply(5, 5, 9, {25{8'd20}});
        #2;
        check_mat("latency_hold_mat", matrix_out, held_mat);
        check_bit("latency_hold_valid", valid, held_valid);
        step_and_check("latency_b");

        // Asynchronous reset mid-cycle, held across edges, then recovery.
        apply(3, 3, 7, {25{8'd33}});
        step_and_check("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check_mat("reset_async_mat", matrix_out, '0);
        check_bit("reset_async_valid", valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_mat("reset_hold_mat", matrix_out, '0);
        check_bit("reset_hold_valid", valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step_and_check("reset_recover");

        // Randomized sweep over all dimension codes, scalars and contents.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 25; k++) mat[k * 8 +: 8] = 8'($urandom_range(0, 255));
            apply(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), mat);
            step_and_check("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
